// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline.
// Sits beside ID and drives the PC, IF/ID and ID/EX write enables together
// with the ID/EX bubble and IF/ID flush controls. It handles multi-cycle
// load-use stalls, a multi-cycle EX-op (multiply) freeze and taken-branch
// flush, and keeps a saturating count of cycles in which the PC was held.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | no stall in progress; detects new load-use / mul / branch
// S_LOAD_STALL | remaining cycles of a load-use stall (cnt = cycles left-1)
// S_MUL_BUSY   | remaining cycles of a multi-cycle EX op (cnt = left-1)

module hazard_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFIDRegRs,
  input  logic [REG_W-1:0] IFIDRegRt,
  input  logic             IFIDUsesRt,
  input  logic [REG_W-1:0] IDEXRegRt,
  input  logic             IDEXMemRead,
  input  logic             IDEXMulStart,
  input  logic             branchTaken,
  input  logic             statClr,
  output logic             PCWr,
  output logic             IFIDWr,
  output logic             IDEXWr,
  output logic             hazCtrl,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] stallCount
);

  // Elaboration-time parameter range checks.
  generate
    if (REG_W < 1) begin : g_bad_reg_w
      $error("hazard_stall_ctrl: REG_W must be >= 1");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
      $error("hazard_stall_ctrl: LOAD_LAT must be in 1..7");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
      $error("hazard_stall_ctrl: MUL_LAT must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_stall_ctrl: CNT_W must be >= 1");
    end
  endgenerate

  // The first stall cycle is spent in IDLE, so the counter is loaded with
  // (remaining cycles - 1) and the state exits when it reads zero.
  localparam int         LOAD_INIT = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
  localparam int         MUL_INIT  = (MUL_LAT > 2)  ? (MUL_LAT - 3)  : 0;
  localparam logic [3:0] LOAD_CNT  = 4'(LOAD_INIT);
  localparam logic [3:0] MUL_CNT   = 4'(MUL_INIT);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MUL_BUSY   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_lu_haz;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] r_stall_cnt;

  // Load-use hazard: MemRead gates both compares; r0 never hazards.
  assign w_lu_haz = IDEXMemRead
                  & (IDEXRegRt != '0)
                  & ((IDEXRegRt == IFIDRegRs)
                     | (IFIDUsesRt & (IDEXRegRt == IFIDRegRt)));

  assign w_cnt_sat  = (r_stall_cnt == {CNT_W{1'b1}});
  assign stallCount = r_stall_cnt;

  // State and down-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and output decode in priority order: mul freeze, branch
  // flush, load stall continuation, new load-use, normal run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    PCWr        = 1'b1;
    IFIDWr      = 1'b1;
    IDEXWr      = 1'b1;
    hazCtrl     = 1'b0;
    IFIDFlush   = 1'b0;

    if (!rst) begin
      if (r_state == S_MUL_BUSY) begin
        PCWr   = 1'b0;
        IFIDWr = 1'b0;
        IDEXWr = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end else if (r_state == S_IDLE && IDEXMulStart && MUL_LAT > 1) begin
        PCWr   = 1'b0;
        IFIDWr = 1'b0;
        IDEXWr = 1'b0;
        // A two-cycle op only needs this one freeze cycle.
        if (MUL_LAT > 2) begin
          w_state_nxt = S_MUL_BUSY;
          w_cnt_nxt   = MUL_CNT;
        end
      end else if (branchTaken) begin
        // Redirect: let the PC load the target, squash IF/ID and bubble ID/EX.
        IFIDFlush   = 1'b1;
        hazCtrl     = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end else if (r_state == S_LOAD_STALL) begin
        PCWr    = 1'b0;
        IFIDWr  = 1'b0;
        hazCtrl = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end else if (r_state == S_IDLE && w_lu_haz) begin
        PCWr    = 1'b0;
        IFIDWr  = 1'b0;
        hazCtrl = 1'b1;
        if (LOAD_LAT > 1) begin
          w_state_nxt = S_LOAD_STALL;
          w_cnt_nxt   = LOAD_CNT;
        end
      end else begin
        // Normal run; also recovers an unencoded state back to IDLE.
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Saturating count of cycles with the PC held; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (statClr) begin
      r_stall_cnt <= '0;
    end else if (!PCWr && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
